// File: rtl/systolic_array.sv
// 4x4 output-stationary systolic MAC array with 8-bit operands and 16-bit accumulators.
// Define SYSTOLIC_SAT_EN to saturate accumulators and row/column sums at 16'hFFFF instead of wrapping.
module systolic_array (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] datain,
    input  logic [31:0] weightin,
    output logic [63:0] macouti,
    output logic [63:0] macoutj
);

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
`ifdef SYSTOLIC_SAT_EN
    localparam int unsigned SW = AW + 2;
`else
    localparam int unsigned SW = AW;
`endif

    logic [DW-1:0] a_q   [N][N];
    logic [DW-1:0] b_q   [N][N];
    logic [AW-1:0] acc_q [N][N];
    logic [DW-1:0] a_c   [N][N];
    logic [DW-1:0] b_c   [N][N];
    logic [AW-1:0] acc_c [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [2*DW-1:0] prod;

            // Edge PEs take the array inputs; interior PEs take their neighbour's registers.
            if (j == 0) begin : g_a_edge
                assign a_c[i][j] = datain[DW*i +: DW];
            end else begin : g_a_fwd
                assign a_c[i][j] = a_q[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_c[i][j] = weightin[DW*j +: DW];
            end else begin : g_b_fwd
                assign b_c[i][j] = b_q[i-1][j];
            end

            assign prod = a_c[i][j] * b_c[i][j];

`ifdef SYSTOLIC_SAT_EN
            logic [AW:0] acc_w;
            assign acc_w       = {1'b0, acc_q[i][j]} + {1'b0, prod};
            assign acc_c[i][j] = acc_w[AW] ? {AW{1'b1}} : acc_w[AW-1:0];
`else
            assign acc_c[i][j] = acc_q[i][j] + prod;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end else begin
                    a_q[i][j]   <= a_c[i][j];
                    b_q[i][j]   <= b_c[i][j];
                    acc_q[i][j] <= acc_c[i][j];
                end
            end
        end
    end

    logic [SW-1:0] row_w [N];
    logic [SW-1:0] col_w [N];

    // Row and column sums, wide enough in saturating builds to detect overflow.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_w[i] = '0;
            col_w[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                row_w[i] = row_w[i] + SW'(acc_q[i][j]);
                col_w[j] = col_w[j] + SW'(acc_q[i][j]);
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
`ifdef SYSTOLIC_SAT_EN
        // A saturated contributor forces the true sum to at least 16'hFFFF, so one clamp covers both cases.
        assign macouti[AW*k +: AW] = (row_w[k][SW-1:AW] != '0) ? {AW{1'b1}} : row_w[k][AW-1:0];
        assign macoutj[AW*k +: AW] = (col_w[k][SW-1:AW] != '0) ? {AW{1'b1}} : col_w[k][AW-1:0];
`else
        assign macouti[AW*k +: AW] = row_w[k];
        assign macoutj[AW*k +: AW] = col_w[k];
`endif
    end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: directed cases plus random streams against a skew-based reference model.
module tb_systolic_array;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] datain = '0;
    logic [31:0] weightin = '0;
    logic [63:0] macouti;
    logic [63:0] macoutj;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] acc_m [4][4];
    logic [31:0] dq [$];
    logic [31:0] wq [$];

    always #5 clk = ~clk;

    systolic_array dut (
        .clk      (clk),
        .reset    (reset),
        .datain   (datain),
        .weightin (weightin),
        .macouti  (macouti),
        .macoutj  (macoutj)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] fold(input int unsigned s);
`ifdef SYSTOLIC_SAT_EN
        return (s > 32'd65535) ? 16'hFFFF : 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    // PE(i,j) at edge t multiplies datain row i from edge t-j with weightin column j from edge t-i.
    task automatic model_edge(input logic [31:0] d, input logic [31:0] w, input logic rst);
        int t;
        logic [31:0] dv, wv;
        int unsigned p;
        if (rst) begin
            dq.delete();
            wq.delete();
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) acc_m[i][j] = '0;
            return;
        end
        dq.push_back(d);
        wq.push_back(w);
        t = dq.size() - 1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (t >= i && t >= j) begin
                    dv = dq[t-j];
                    wv = wq[t-i];
                    p  = 32'(dv[8*i +: 8]) * 32'(wv[8*j +: 8]);
                    acc_m[i][j] = fold(32'(acc_m[i][j]) + p);
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_rows();
        logic [63:0] r;
        int unsigned s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += 32'(acc_m[i][j]);
            r[16*i +: 16] = fold(s);
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_cols();
        logic [63:0] r;
        int unsigned s;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int i = 0; i < 4; i++) s += 32'(acc_m[i][j]);
            r[16*j +: 16] = fold(s);
        end
        return r;
    endfunction

    task automatic cycle(input logic [31:0] d, input logic [31:0] w, input logic rst);
        datain   = d;
        weightin = w;
        reset    = rst;
        @(posedge clk);
        model_edge(d, w, rst);
        #1;
        check("model_rows", macouti, exp_rows());
        check("model_cols", macoutj, exp_cols());
    endtask

    initial begin
        logic [7:0]  a_m [2][2];
        logic [7:0]  b_m [2][2];
        logic [63:0] er, ec;
        logic [31:0] d, w;
        int unsigned s;

        // Reset with random inputs, then again after accumulating.
        cycle($urandom, $urandom, 1'b1);
        check("reset_rows", macouti, 64'h0);
        check("reset_cols", macoutj, 64'h0);
        for (int n = 0; n < 20; n++) cycle($urandom, $urandom, 1'b0);
        cycle($urandom, $urandom, 1'b1);
        check("reset_clears_rows", macouti, 64'h0);
        check("reset_clears_cols", macoutj, 64'h0);

        // Zero activations: nothing accumulates.
        for (int n = 0; n < 8; n++) cycle(32'h0, 32'h0403_0201, 1'b0);
        check("zero_data_rows", macouti, 64'h0);
        check("zero_data_cols", macoutj, 64'h0);

        // Row broadcast: one activation walks across row 0.
        cycle($urandom, $urandom, 1'b1);
        cycle(32'h0000_0001, 32'h0403_0201, 1'b0);
        check("bcast_e1", 64'(macouti[15:0]), 64'd1);
        cycle(32'h0, 32'h0403_0201, 1'b0);
        check("bcast_e2", 64'(macouti[15:0]), 64'd3);
        cycle(32'h0, 32'h0403_0201, 1'b0);
        check("bcast_e3", 64'(macouti[15:0]), 64'd6);
        cycle(32'h0, 32'h0403_0201, 1'b0);
        check("bcast_rows", macouti, 64'd10);
        check("bcast_cols", macoutj, 64'h0004_0003_0002_0001);

        // Same-cycle pulses on row 3 and column 3 meet at PE(3,3) three edges later.
        cycle($urandom, $urandom, 1'b1);
        cycle(32'h0100_0000, 32'h0100_0000, 1'b0);
        cycle(32'h0, 32'h0, 1'b0);
        cycle(32'h0, 32'h0, 1'b0);
        check("pulse_k2_rows", macouti, 64'h0);
        cycle(32'h0, 32'h0, 1'b0);
        check("pulse_k3_rows", macouti, 64'h0001_0000_0000_0000);
        check("pulse_k3_cols", macoutj, 64'h0001_0000_0000_0000);
        for (int n = 0; n < 4; n++) cycle(32'h0, 32'h0, 1'b0);

        // Row pulse three cycles after the column pulse: they never meet.
        cycle($urandom, $urandom, 1'b1);
        cycle(32'h0, 32'h0100_0000, 1'b0);
        cycle(32'h0, 32'h0, 1'b0);
        cycle(32'h0, 32'h0, 1'b0);
        cycle(32'h0100_0000, 32'h0, 1'b0);
        for (int n = 0; n < 8; n++) cycle(32'h0, 32'h0, 1'b0);
        check("stagger_rows", macouti, 64'h0);
        check("stagger_cols", macoutj, 64'h0);

        // Wrap / saturation: acc(0,0)=2*0xFE01, acc(0,1)=0xFE01 after two edges.
        cycle($urandom, $urandom, 1'b1);
        cycle(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cycle(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`ifdef SYSTOLIC_SAT_EN
        check("wrap_lane0", 64'(macouti[15:0]), 64'hFFFF);
`else
        check("wrap_lane0", 64'(macouti[15:0]), 64'hFA03);
`endif
        for (int n = 0; n < 8; n++) cycle(32'h0, 32'h0, 1'b0);

        // 2x2 matrix product with skewed operand streams.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 2; k++) begin
                    a_m[i][k] = 8'($urandom_range(0, 255));
                    b_m[i][k] = 8'($urandom_range(0, 255));
                end
            cycle($urandom, $urandom, 1'b1);
            for (int t = 0; t < 7; t++) begin
                d = '0;
                w = '0;
                for (int i = 0; i < 2; i++)
                    if (t - i >= 0 && t - i < 2) d[8*i +: 8] = a_m[i][t-i];
                for (int j = 0; j < 2; j++)
                    if (t - j >= 0 && t - j < 2) w[8*j +: 8] = b_m[t-j][j];
                cycle(d, w, 1'b0);
            end
            er = '0;
            ec = '0;
            for (int i = 0; i < 2; i++) begin
                s = 0;
                for (int j = 0; j < 2; j++)
                    for (int k = 0; k < 2; k++) s += 32'(a_m[i][k]) * 32'(b_m[k][j]);
                er[16*i +: 16] = fold(s);
            end
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < 2; k++) s += 32'(a_m[i][k]) * 32'(b_m[k][j]);
                ec[16*j +: 16] = fold(s);
            end
            check("matmul_rows", macouti, er);
            check("matmul_cols", macoutj, ec);
        end

        // Random streams with occasional mid-stream reset.
        for (int n = 0; n < 400; n++)
            cycle($urandom, $urandom, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
